// File: rtl/rvm_mem_responder.sv
// Single-port word memory behind a req/gnt core bus with a fixed, parameterised
// response latency. One transaction in flight at a time; responses are registered.
module rvm_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic        mem_rerror,
    output logic [31:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("rvm_mem_responder: LATENCY must be within 1..15");
        end
        if (DEPTH < 16 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rvm_mem_responder: DEPTH must be a power of two within 16..65536");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_mem [DEPTH];
    logic        r_err;
    logic [31:0] r_rword;

    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_new_word;
    logic          w_resp_err;
    logic [31:0]   w_resp_word;

    assign w_err      = (mem_addr[1:0] != 2'b00) || ({2'b00, mem_addr[31:2]} >= 32'(DEPTH));
    assign w_idx      = mem_addr[AW+1:2];
    assign w_new_word = (mem_wen || w_err) ? 32'h0 : r_mem[w_idx];

    // With LATENCY=1 the response register loads on the acceptance edge itself,
    // so the result has to bypass the captured copy.
    assign w_resp_err  = (r_state == IDLE) ? w_err      : r_err;
    assign w_resp_word = (r_state == IDLE) ? w_new_word : r_rword;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        mem_gnt     = 1'b0;
        case (r_state)
            IDLE: begin
                mem_gnt = resetn && mem_req;
                if (mem_gnt) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = RESP;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_err      <= 1'b0;
            r_rword    <= 32'h0;
            mem_rvalid <= 1'b0;
            mem_rerror <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (mem_gnt) begin
                r_err   <= w_err;
                r_rword <= w_new_word;
            end
            mem_rvalid <= (w_state_nxt == RESP);
            mem_rerror <= (w_state_nxt == RESP) && w_resp_err;
            mem_rdata  <= (w_state_nxt == RESP) ? w_resp_word : 32'h0;
        end
    end

    // Storage is never reset; a write commits at its acceptance edge regardless
    // of what later happens to the response.
    always_ff @(posedge clk) begin
        if (mem_gnt && mem_wen && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb[b]) r_mem[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Randomised bench for rvm_mem_responder: LATENCY=1 and LATENCY=4 instances
// checked against a transaction-level model (word array + earliest-grant cycle).
module tb_rvm_mem_responder;

    localparam int D = 64;

    logic        clk = 1'b0;
    logic        rstn   [2];
    logic        req    [2];
    logic        wen    [2];
    logic [3:0]  strb   [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic        rerror [2];
    logic [31:0] rdata  [2];

    logic [31:0] mdl [2][D];
    int          free_at [2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rvm_mem_responder #(.DEPTH(D), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(rstn[0]), .mem_req(req[0]), .mem_wen(wen[0]),
        .mem_strb(strb[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_gnt(gnt[0]), .mem_rvalid(rvalid[0]), .mem_rerror(rerror[0]),
        .mem_rdata(rdata[0])
    );

    rvm_mem_responder #(.DEPTH(D), .LATENCY(4)) u_lat4 (
        .clk(clk), .resetn(rstn[1]), .mem_req(req[1]), .mem_wen(wen[1]),
        .mem_strb(strb[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_gnt(gnt[1]), .mem_rvalid(rvalid[1]), .mem_rerror(rerror[1]),
        .mem_rdata(rdata[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Drive one request, wait for the grant the model predicts, then check the response.
    task automatic txn(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
        int          L;
        int          g;
        int          idx;
        bit          err;
        logic [31:0] exp_rd;
        L = lat_of(d);
        req[d] = 1'b1; wen[d] = w; strb[d] = s; addr[d] = a; wdata[d] = wd;
        g = (free_at[d] > cyc) ? free_at[d] : cyc;
        while (1) begin
            @(negedge clk);
            chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(cyc == g));
            if (cyc >= g) break;
            chk($sformatf("rvalid_idle%0d", d), 32'(rvalid[d]), 32'h0);
            step();
        end
        err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(D));
        idx = err ? 0 : int'(a[31:2]);
        exp_rd = (err || w) ? 32'h0 : mdl[d][idx];
        if (!err && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
        free_at[d] = g + L + 1;
        step();
        if (!hold) req[d] = 1'b0;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(k == L));
            chk($sformatf("gnt_busy%0d", d), 32'(gnt[d]), 32'h0);
            chk($sformatf("rerror%0d", d), 32'(rerror[d]), 32'(k == L && err));
            chk($sformatf("rdata%0d", d), rdata[d], (k == L) ? exp_rd : 32'h0);
            step();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = {24'h0, 6'($urandom_range(0, D - 1)), 2'($urandom_range(1, 3))};
            1:       a = 32'(D * 4) + 32'($urandom_range(0, 255) * 4);
            default: a = 32'($urandom_range(0, D - 1) * 4);
        endcase
        return a;
    endfunction

    initial begin
        int g;
        logic [31:0] v;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; req[d] = 1'b1; wen[d] = 1'b0; strb[d] = 4'h0;
            addr[d] = 32'h0; wdata[d] = 32'h0; free_at[d] = 0;
        end
        // Reset state, with a request pending that must not be granted.
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'h0);
                chk($sformatf("rst_rvalid%0d", d), 32'(rvalid[d]), 32'h0);
                chk($sformatf("rst_rerror%0d", d), 32'(rerror[d]), 32'h0);
                chk($sformatf("rst_rdata%0d", d), rdata[d], 32'h0);
            end
        end
        step();
        for (int d = 0; d < 2; d++) begin req[d] = 1'b0; rstn[d] = 1'b1; end
        step();

        // Give every word a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < D; i++) txn(d, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);

        // Full write then read back.
        txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        chk("model_deadbeef", mdl[0][4], 32'hDEADBEEF);

        // Byte strobes.
        txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0);
        txn(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 1'b0);
        txn(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        txn(0, 1'b1, 4'h0, 32'h20, 32'h55555555, 1'b0);
        txn(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);

        // Back-to-back held request on the slow instance: grants every 5 cycles.
        txn(1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1);
        txn(1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1);
        txn(1, 1'b0, 4'h0, 32'hC, 32'h0, 1'b0);

        // Error cases, then confirm no word was disturbed.
        txn(0, 1'b0, 4'h0, 32'h2, 32'h0, 1'b0);
        txn(0, 1'b1, 4'hF, 32'(D * 4), 32'hFFFFFFFF, 1'b0);
        txn(1, 1'b1, 4'hF, 32'h7, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < D; i++) txn(0, 1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b0);

        // Reset two cycles after a write grant drops the response, keeps the write.
        v = $urandom;
        req[1] = 1'b1; wen[1] = 1'b1; strb[1] = 4'hF; addr[1] = 32'h40; wdata[1] = v;
        g = (free_at[1] > cyc) ? free_at[1] : cyc;
        while (1) begin
            @(negedge clk);
            chk("rst_mid_gnt", 32'(gnt[1]), 32'(cyc == g));
            if (cyc >= g) break;
            step();
        end
        mdl[1][16] = v;
        step();
        req[1] = 1'b0;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rvalid[1]), 32'h0);
        step();
        rstn[1] = 1'b0; req[1] = 1'b1; wen[1] = 1'b0;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rvalid[1]), 32'h0);
        chk("rst_mid_gnt_low", 32'(gnt[1]), 32'h0);
        step();
        rstn[1] = 1'b1; req[1] = 1'b0;
        free_at[1] = cyc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_rvalid", 32'(rvalid[1]), 32'h0);
            step();
        end
        txn(1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);

        // Random traffic on both instances with idle gaps.
        for (int n = 0; n < 200; n++) begin
            int d;
            d = int'($urandom_range(0, 1));
            txn(d, 1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        // Idle bus.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("idle_gnt%0d", d), 32'(gnt[d]), 32'h0);
                chk($sformatf("idle_rvalid%0d", d), 32'(rvalid[d]), 32'h0);
                chk($sformatf("idle_rerror%0d", d), 32'(rerror[d]), 32'h0);
                chk($sformatf("idle_rdata%0d", d), rdata[d], 32'h0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
